smi_master: RTL and testbench

- IEEE 802.3 Clause 22 management (SMI/MDIO) master. It sequences read and write frames to the GMII PHY so the PHY can be configured and queried (link, speed, autoneg) before and during rx_ethernet operation.
- Sits in top under the "SMI logic" slot and drives the top-level MDC/MDIO pins. Top owns the MDIO tri-state buffer; this block exposes a split O/OE/I interface.
- Future CSR/PicoRV logic issues one-transaction-at-a-time requests.

---
 rtl/smi_pkg.sv | 43 ++++
 rtl/smi_clkdiv.sv | 43 ++++
 rtl/smi_master.sv | 141 ++++++++++++++
 tb/tb_smi_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/smi_pkg.sv
`default_nettype none
// ============================================================================
// smi_pkg : Clause 22 MDIO frame constants, FSM encoding and frame builder.
// Rev 1.0
// ============================================================================
package smi_pkg;

  localparam logic [1:0] SMI_ST    = 2'b01;
  localparam logic [1:0] SMI_OP_WR = 2'b01;
  localparam logic [1:0] SMI_OP_RD = 2'b10;
  localparam logic [1:0] SMI_TA_WR = 2'b10;

  localparam int PRE_END    = 31;
  localparam int TA_START   = 46;
  localparam int TA_LAST    = 47;
  localparam int DATA_START = 48;
  localparam int FRAME_BITS = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DONE  = 2'd2
  } smi_state_t;

  // Frame in transmit order (bit 0 at the MSB); read frames carry 1s in the
  // TA/DATA slots so the idle-high level falls out of the shift register.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic        we,
    input logic [4:0]  phy_addr,
    input logic [4:0]  reg_addr,
    input logic [15:0] wdata
  );
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] data;
    op   = we ? SMI_OP_WR : SMI_OP_RD;
    ta   = we ? SMI_TA_WR : 2'b11;
    data = we ? wdata : 16'hFFFF;
    return {{(PRE_END + 1){1'b1}}, SMI_ST, op, phy_addr, reg_addr, ta, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/smi_clkdiv.sv
`default_nettype none
// ============================================================================
// smi_clkdiv : MDC generator with one-cycle rise/fall strobes, idle while
//              disabled. Rev 1.0
// ============================================================================
module smi_clkdiv #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_mdc,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int            CW     = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_mdc;
  logic          w_wrap;

  // Strobes flag the cycle before the CLK edge on which MDC changes level.
  assign w_wrap     = i_en && (r_cnt == C_LAST);
  assign o_rise_stb = w_wrap && !r_mdc;
  assign o_fall_stb = w_wrap && r_mdc;
  assign o_mdc      = r_mdc;

  always_ff @(posedge clk) begin
    if (!rst || !i_en) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/smi_master.sv
`default_nettype none
// ============================================================================
// smi_master : IEEE 802.3 Clause 22 MDIO master, one read/write frame per
//              request, split O/OE/I pad interface. Rev 1.0
// ============================================================================
module smi_master
  import smi_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        ta_err,
  output logic        MDC,
  output logic        MDIO_O,
  output logic        MDIO_OE,
  input  logic        MDIO_I
);

  smi_state_t            r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [15:0]           r_rdata;
  logic                  r_rvalid;
  logic                  r_ta_err;
  logic                  r_mdio_o;
  logic                  r_oe;
  logic                  r_we;
  logic [FRAME_BITS-1:0] r_sr;
  logic [5:0]            r_bit;

  logic                  w_rise;
  logic                  w_fall;
  logic                  w_mdc;
  logic [FRAME_BITS-1:0] w_frame;
  logic [5:0]            w_next_bit;
  logic                  w_released;
  logic                  w_last_bit;

  smi_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .clk        (CLK),
    .rst        (rst),
    .i_en       (r_busy),
    .o_mdc      (w_mdc),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall)
  );

  assign w_frame    = build_frame(we, phy_addr, reg_addr, wdata);
  assign w_next_bit = r_bit + 6'd1;
  assign w_released = !r_we && (w_next_bit >= 6'(TA_START));
  assign w_last_bit = (r_bit == 6'(FRAME_BITS - 1));

  // Samples shift in at the LSB while transmit bits leave at the MSB, so
  // after 64 rises the low 17 bits hold the TA-second sample and read data.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_ta_err <= 1'b0;
      r_mdio_o <= 1'b1;
      r_oe     <= 1'b0;
      r_we     <= 1'b0;
      r_sr     <= '0;
      r_bit    <= '0;
    end else begin
      r_done   <= 1'b0;
      r_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (req) begin
            r_state  <= ST_FRAME;
            r_busy   <= 1'b1;
            r_we     <= we;
            r_sr     <= w_frame;
            r_bit    <= '0;
            r_mdio_o <= w_frame[FRAME_BITS-1];
            r_oe     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FRAME: begin
          if (w_rise) begin
            r_sr <= {r_sr[FRAME_BITS-2:0], MDIO_I};
          end
          if (w_fall) begin
            if (w_last_bit) begin
              r_state  <= ST_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_oe     <= 1'b0;
              r_mdio_o <= 1'b1;
              if (!r_we) begin
                r_rdata  <= r_sr[FRAME_BITS-DATA_START-1:0];
                r_rvalid <= 1'b1;
                r_ta_err <= r_sr[FRAME_BITS-1-TA_LAST];
              end else begin
                r_ta_err <= 1'b0;
              end
            end else begin
              r_bit    <= w_next_bit;
              r_mdio_o <= w_released ? 1'b1 : r_sr[FRAME_BITS-1];
              r_oe     <= !w_released;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rvalid;
  assign ta_err      = r_ta_err;
  assign MDC         = w_mdc;
  assign MDIO_O      = r_mdio_o;
  assign MDIO_OE     = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_smi_master.sv
`default_nettype none
// ============================================================================
// tb_smi_master : directed + randomized bench for smi_master with an MDIO
//                 bit-level PHY model and frame reference. Rev 1.0
// ============================================================================
module tb_smi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, sel, req, we;
  logic        mdio_i = 1'b1;
  logic [4:0]  phy_addr, reg_addr;
  logic [15:0] wdata;

  logic        busy2, done2, rv2, ta2, mdc2, mo2, oe2;
  logic        busy1, done1, rv1, ta1, mdc1, mo1, oe1;
  logic [15:0] rd2, rd1;
  logic        req2, req1;
  assign req2 = req & ~sel;
  assign req1 = req & sel;

  smi_master #(.CLK_DIV(2)) u_dut_div2 (
    .CLK(clk), .rst(rst), .req(req2), .we(we), .phy_addr(phy_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy2), .done(done2),
    .rdata(rd2), .rdata_valid(rv2), .ta_err(ta2), .MDC(mdc2),
    .MDIO_O(mo2), .MDIO_OE(oe2), .MDIO_I(mdio_i)
  );

  smi_master #(.CLK_DIV(1)) u_dut_div1 (
    .CLK(clk), .rst(rst), .req(req1), .we(we), .phy_addr(phy_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy1), .done(done1),
    .rdata(rd1), .rdata_valid(rv1), .ta_err(ta1), .MDC(mdc1),
    .MDIO_O(mo1), .MDIO_OE(oe1), .MDIO_I(mdio_i)
  );

  logic        busy, done, rdata_valid, ta_err, mdc, mdio_o, mdio_oe;
  logic [15:0] rdata;
  assign busy        = sel ? busy1 : busy2;
  assign done        = sel ? done1 : done2;
  assign rdata_valid = sel ? rv1   : rv2;
  assign ta_err      = sel ? ta1   : ta2;
  assign mdc         = sel ? mdc1  : mdc2;
  assign mdio_o      = sel ? mo1   : mo2;
  assign mdio_oe     = sel ? oe1   : oe2;
  assign rdata       = sel ? rd1   : rd2;

  int nchk = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // PHY side: captures the line at each MDC rise, drives MDIO_I per bit.
  int          rise_cnt = 0, busy_cnt = 0, done_cnt = 0, rv_cnt = 0;
  logic        mdc_prev = 1'b0;
  logic [63:0] cap_o, cap_oe;
  bit          phy_bits [64];

  always @(negedge clk) begin
    if (mdc && !mdc_prev && rise_cnt < 64) begin
      cap_o[63 - rise_cnt]  = mdio_o;
      cap_oe[63 - rise_cnt] = mdio_oe;
      rise_cnt++;
    end
    mdc_prev = mdc;
    mdio_i   = (rise_cnt < 64) ? phy_bits[rise_cnt] : 1'b1;
    if (busy)        busy_cnt++;
    if (done)        done_cnt++;
    if (rdata_valid) rv_cnt++;
  end

  // Reference frame: the Clause 22 field list laid out bit by bit.
  task automatic build_exp(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, output logic [63:0] eo, output logic [63:0] eoe);
    bit q_o[$];
    bit q_e[$];
    for (int i = 0; i < 32; i++) begin q_o.push_back(1'b1); q_e.push_back(1'b1); end
    q_o.push_back(1'b0); q_e.push_back(1'b1);
    q_o.push_back(1'b1); q_e.push_back(1'b1);
    q_o.push_back(wr ? 1'b0 : 1'b1); q_e.push_back(1'b1);
    q_o.push_back(wr ? 1'b1 : 1'b0); q_e.push_back(1'b1);
    for (int i = 4; i >= 0; i--) begin q_o.push_back(pa[i]); q_e.push_back(1'b1); end
    for (int i = 4; i >= 0; i--) begin q_o.push_back(ra[i]); q_e.push_back(1'b1); end
    if (wr) begin
      q_o.push_back(1'b1); q_e.push_back(1'b1);
      q_o.push_back(1'b0); q_e.push_back(1'b1);
      for (int i = 15; i >= 0; i--) begin q_o.push_back(wd[i]); q_e.push_back(1'b1); end
    end else begin
      for (int i = 0; i < 18; i++) begin q_o.push_back(1'b1); q_e.push_back(1'b0); end
    end
    for (int k = 0; k < 64; k++) begin
      eo[63 - k]  = q_o[k];
      eoe[63 - k] = q_e[k];
    end
  endtask

  task automatic set_phy(input bit wr, input bit drv, input logic [15:0] pd);
    for (int k = 0; k < 64; k++) phy_bits[k] = 1'b1;
    if (!wr && drv) begin
      phy_bits[47] = 1'b0;
      for (int k = 0; k < 16; k++) phy_bits[48 + k] = pd[15 - k];
    end
  endtask

  logic [15:0] last_rd [2];

  task automatic run_txn(input bit s, input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input bit drv, input logic [15:0] pd, input bit dbl);
    logic [63:0] eo, eoe;
    logic [15:0] exp_rd;
    int a, div, n;
    div = s ? 1 : 2;
    build_exp(wr, pa, ra, wd, eo, eoe);
    set_phy(wr, drv, pd);
    exp_rd = wr ? last_rd[s] : (drv ? pd : 16'hFFFF);
    sel = s; rise_cnt = 0; busy_cnt = 0; done_cnt = 0; rv_cnt = 0;
    we = wr; phy_addr = pa; reg_addr = ra; wdata = wd; req = 1'b1;
    tick;
    a = cyc;
    req = 1'b0;
    we = 1'($urandom); phy_addr = 5'($urandom); reg_addr = 5'($urandom); wdata = 16'($urandom);
    check("accept_state", {busy, mdio_oe, mdio_o, mdc}, 4'b1110);
    if (dbl) begin
      repeat (9) tick;
      req = 1'b1; we = ~wr; phy_addr = ~pa; reg_addr = ~ra;
      tick;
      req = 1'b0;
    end
    n = 0;
    while (!done && n < 300 * div) begin tick; n++; end
    check("done_latency", 64'(cyc - a), 64'(128 * div));
    check("busy_cycles", 64'(busy_cnt), 64'(128 * div));
    check("done_cycle_outputs", {done, busy, mdc, mdio_oe, rdata_valid}, {4'b1000, ~wr});
    check("rdata", rdata, exp_rd);
    if (!wr) check("ta_err", ta_err, !drv);
    check("frame_bits", cap_o, eo);
    check("frame_oe", cap_oe, eoe);
    check("rise_count", 64'(rise_cnt), 64'd64);
    tick; tick;
    check("single_done", 64'(done_cnt), 64'd1);
    check("rvalid_count", 64'(rv_cnt), wr ? 64'd0 : 64'd1);
    last_rd[s] = exp_rd;
  endtask

  initial begin
    logic [63:0] eo, eoe;
    int n, d1, d2;
    logic [4:0]  pa, ra;
    logic [15:0] wd;
    rst = 1'b0; sel = 1'b0; req = 1'b0; we = 1'b0;
    phy_addr = '0; reg_addr = '0; wdata = '0;
    for (int k = 0; k < 64; k++) phy_bits[k] = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (3) tick;
    check("reset_div2", {busy2, done2, rv2, ta2, mdc2, oe2, mo2, rd2}, {7'b0000001, 16'h0000});
    check("reset_div1", {busy1, done1, rv1, ta1, mdc1, oe1, mo1, rd1}, {7'b0000001, 16'h0000});
    rst = 1'b1;
    tick;

    run_txn(1'b0, 1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000, 1'b0);
    run_txn(1'b0, 1'b0, 5'h1F, 5'h01, 16'h0000, 1'b1, 16'h796D, 1'b0);
    run_txn(1'b0, 1'b0, 5'($urandom), 5'($urandom), 16'h0000, 1'b0, 16'h0000, 1'b0);
    run_txn(1'b0, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_txn(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
              1'b1, 16'($urandom), 1'b0);
    end

    // Abort a write around bit 40 with reset.
    sel = 1'b0; set_phy(1'b1, 1'b0, 16'h0); rise_cnt = 0; done_cnt = 0;
    we = 1'b1; phy_addr = 5'h0A; reg_addr = 5'h04; wdata = 16'hA5A5; req = 1'b1;
    tick;
    req = 1'b0;
    n = 0;
    while (rise_cnt < 40 && n < 500) begin tick; n++; end
    check("reach_bit40", 64'(rise_cnt), 64'd40);
    rst = 1'b0;
    tick;
    check("reset_abort", {busy, done, mdc, mdio_oe, mdio_o}, 5'b00001);
    rst = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (300) tick;
    check("no_done_after_abort", 64'(done_cnt), 64'd0);
    run_txn(1'b0, 1'b1, 5'h0A, 5'h04, 16'hA5A5, 1'b0, 16'h0000, 1'b0);

    // Back-to-back on the CLK_DIV=1 instance with req held through done.
    pa = 5'($urandom); ra = 5'($urandom); wd = 16'($urandom);
    build_exp(1'b1, pa, ra, wd, eo, eoe);
    set_phy(1'b1, 1'b0, 16'h0);
    sel = 1'b1; rise_cnt = 0; done_cnt = 0;
    we = 1'b1; phy_addr = pa; reg_addr = ra; wdata = wd; req = 1'b1;
    tick;
    n = 0;
    while (!done && n < 400) begin tick; n++; end
    d1 = cyc;
    check("b2b_first_done", done, 1'b1);
    tick;
    check("b2b_restart", {busy, mdio_oe, mdio_o, mdc}, 4'b1110);
    req = 1'b0; rise_cnt = 0;
    n = 0;
    while (!done && n < 400) begin tick; n++; end
    d2 = cyc;
    check("b2b_done_spacing", 64'(d2 - d1), 64'd129);
    check("b2b_frame_bits", cap_o, eo);
    tick; tick;
    check("b2b_done_count", 64'(done_cnt), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire
